// File: rtl/if_stage.sv
// Instruction-fetch stage of the P7 pipelined MIPS core.
// Holds the fetch PC and the IF/ID pipeline register, drives the
// instruction-memory address, and tags fetch address errors (AdEL)
// and branch-delay-slot membership for the downstream CP0 path.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        npc_valid,
    input  logic [31:0] npc_pc,
    input  logic        branch_d_in,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic        bd_d,
    output logic [4:0]  exc_code_d
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_plus4;
    logic        fetch_err;

    // The memory address is the fetch PC itself, so im_addr only ever
    // depends on the pc_f register.
    assign im_addr  = pc_f;
    assign pc_plus4 = pc_f + 32'd4;

    // A misaligned or out-of-text-segment PC is still fetched, but the
    // returned word is replaced by a nop and the error rides along.
    assign fetch_err = (pc_f[1:0] != 2'b00) | (pc_f < TEXT_LO) | (pc_f > TEXT_HI);

    // Fetch PC: exception redirect beats stall, stall beats a D-stage
    // redirect (the branch stays in D and asks again), else sequential.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f <= RESET_PC;
        end else if (exc_req) begin
            pc_f <= HANDLER_PC;
        end else if (stall) begin
            pc_f <= pc_f;
        end else if (npc_valid) begin
            pc_f <= npc_pc;
        end else begin
            pc_f <= pc_plus4;
        end
    end

    // IF/ID register: flushed on exception, held on stall, otherwise
    // captures the fetched word; the delay slot is never squashed here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_d    <= 32'd0;
            pc_d       <= 32'd0;
            pc4_d      <= 32'd0;
            valid_d    <= 1'b0;
            bd_d       <= 1'b0;
            exc_code_d <= EXC_NONE;
        end else if (exc_req) begin
            instr_d    <= 32'd0;
            pc_d       <= 32'd0;
            pc4_d      <= 32'd0;
            valid_d    <= 1'b0;
            bd_d       <= 1'b0;
            exc_code_d <= EXC_NONE;
        end else if (!stall) begin
            instr_d    <= fetch_err ? 32'd0 : im_rdata;
            pc_d       <= pc_f;
            pc4_d      <= pc_plus4;
            valid_d    <= 1'b1;
            bd_d       <= branch_d_in;
            exc_code_d <= fetch_err ? EXC_ADEL : EXC_NONE;
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the P7 pipelined MIPS core. It holds the fetch PC and the IF/ID pipeline register, and drives the instruction-memory address. Each cycle it selects the next PC from the D-stage next-PC result, sequential PC+4, or the exception-handler entry. It also flags fetch address errors (AdEL) and delay-slot membership for the CP0 exception path downstream.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- HANDLER_PC, 32'h0000_4180, exception handler entry
- TEXT_LO, 32'h0000_3000, lowest legal fetch address
- TEXT_HI, 32'h0000_6FFC, highest legal fetch address

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- stall  in  1  hazard unit: hold the PC and the IF/ID register
- exc_req  in  1  CP0: exception or interrupt taken this cycle; redirect to HANDLER_PC and flush IF/ID
- npc_valid  in  1  D-stage branch is taken, jump, jr/jalr, or eret
- npc_pc  in  32  next-PC value from the D-stage next-PC unit
- branch_d_in  in  1  instruction currently in D is a branch or jump (delay-slot marker)
- im_addr  out  32  instruction memory address; combinational, equal to pc_f
- im_rdata  in  32  instruction word read combinationally at im_addr
- pc_f  out  32  current fetch PC
- instr_d  out  32  instruction word in the IF/ID register
- pc_d  out  32  PC of instr_d; used for EPC
- pc4_d  out  32  pc_d + 4; feeds the next-PC unit
- valid_d  out  1  IF/ID holds a real instruction
- bd_d  out  1  instr_d sits in a branch delay slot
- exc_code_d  out  5  fetch exception code: 0 means none, 4 means AdEL

## Operation
- **Next-PC priority:** exc_req, then stall, then npc_valid, then PC+4.
  - exc_req: pc_f <= HANDLER_PC.
  - stall: pc_f holds. npc_valid is ignored, because the branch stays in D and asserts npc_valid again on a later cycle.
  - npc_valid: pc_f <= npc_pc.
  - Otherwise: pc_f <= pc_f + 4, computed modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- **Fetch check:** fetch_err = (pc_f[1:0] != 0) | (pc_f < TEXT_LO) | (pc_f > TEXT_HI). Comparisons are unsigned.
- **IF/ID register update:**
  - exc_req: flush. instr_d, pc_d, pc4_d, and exc_code_d go to 0; valid_d and bd_d go to 0.
  - stall without exc_req: every field holds.
  - Otherwise the register loads:
    - instr_d <= fetch_err ? 0 : im_rdata (a nop on error)
    - pc_d <= pc_f
    - pc4_d <= pc_f + 4
    - valid_d <= 1
    - bd_d <= branch_d_in
    - exc_code_d <= fetch_err ? 5'd4 : 5'd0
- **Delay slot:** the instruction fetched while a branch or jump is in D is its delay slot. It is always fetched and never squashed by the branch; only exc_req squashes it.
- **eret:** arrives as npc_valid with npc_pc = EPC. No special handling is needed in this block.
- **Misaligned or out-of-range PC:** the PC is still driven onto im_addr. im_rdata is discarded and the error travels down the pipeline with the instruction.

## Timing
- **Reset:** while reset is low, all outputs are forced asynchronously:
  - pc_f = im_addr = RESET_PC
  - instr_d = 0, pc_d = 0, pc4_d = 0
  - valid_d = 0, bd_d = 0, exc_code_d = 0
- **Reset release:** the first rising edge after reset goes high loads the IF/ID register from RESET_PC and advances pc_f to RESET_PC+4.
- **Latency:**
  - A redirect on npc_valid in cycle N puts npc_pc on im_addr in cycle N+1.
  - The redirected instruction appears on instr_d in cycle N+2.
  - The delay-slot instruction appears on instr_d in cycle N+1 with bd_d = 1.
- **Simultaneous events:**
  - exc_req with stall: exc_req wins; PC redirects and IF/ID flushes.
  - exc_req with npc_valid: exc_req wins.
  - stall with npc_valid: full hold.
- **Reset mid-operation:** an asynchronous clear that overrides any in-flight redirect or stall. No partial update is visible.
- **Combinational paths:** im_addr is the only combinational output, and it depends only on the pc_f register. No input reaches any output combinationally.

## Test plan
- **Reset:** hold reset low for 3 cycles, release, run 3 free cycles.
  - During reset: pc_f = 0x3000, valid_d = 0.
  - Then pc_d steps 0x3000, 0x3004, 0x3008, with pc4_d = pc_d + 4.
- **Taken branch with delay slot:** branch at 0x3008 in D, branch_d_in = 1, npc_valid = 1, npc_pc = 0x3100.
  - Next cycle: instr_d comes from 0x300C with bd_d = 1.
  - The cycle after: pc_d = 0x3100 with bd_d = 0.
- **Stall over redirect:** hold stall for 2 cycles with npc_valid = 1.
  - pc_f, instr_d, and pc_d are unchanged across both cycles.
  - After stall drops, npc_valid is applied once.
- **Exception beats stall:** exc_req = 1 with stall = 1 and npc_valid = 1.
  - Next cycle: pc_f = 0x4180, valid_d = 0, instr_d = 0.
  - The following cycle: pc_d = 0x4180.
- **Fetch errors:**
  - npc_pc = 0x3002: pc_d = 0x3002, instr_d = 0, exc_code_d = 4, valid_d = 1.
  - npc_pc = 0x7000: exc_code_d = 4.
  - npc_pc = 0x6FFC: exc_code_d = 0.
- **Async reset mid-redirect:** assert reset low between clock edges while npc_valid = 1. pc_f drops to 0x3000 immediately, without waiting for an edge.
